// File: rtl/mips_debug_unit.sv
// Host debug controller for the MIPS core: byte-stream commands load instruction memory,
// run or single-step the pipeline, then stream back the PC and all 32 GPRs.
module mips_debug_unit #(
  parameter int IMEM_ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_valid,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready,
  output logic                   o_imem_we,
  output logic [IMEM_ADDR_W-1:0] o_imem_addr,
  output logic [31:0]            o_imem_wdata,
  output logic                   o_cpu_reset,
  output logic                   o_cpu_enable,
  input  logic                   i_halt,
  input  logic [31:0]            i_pc,
  output logic [4:0]             o_reg_addr,
  input  logic [31:0]            i_reg_data,
  output logic                   o_busy
);

  localparam logic [7:0] CMD_LOAD  = 8'h4C;
  localparam logic [7:0] CMD_RUN   = 8'h52;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] DUMP_LAST = 8'd131;
  localparam logic [IMEM_ADDR_W-1:0] ADDR_ONE = 1;

  typedef enum logic [3:0] {
    IDLE, LD_CNT0, LD_CNT1, LD_DATA, LD_WR, RUN, STEP, DUMP_RD, DUMP_TX, ACK
  } state_t;

  state_t                 state_reg, state_next;
  logic [15:0]            word_cnt_reg;
  logic [IMEM_ADDR_W-1:0] addr_reg;
  logic [1:0]             byte_idx_reg;
  logic [31:0]            data_sr_reg;
  logic [7:0]             dump_cnt_reg;
  logic                   rd_phase_reg;
  logic [31:0]            tx_word_reg;
  logic                   cpu_reset_reg;

  assign o_imem_addr  = addr_reg;
  assign o_imem_wdata = data_sr_reg;
  assign o_cpu_reset  = cpu_reset_reg;
  assign o_busy       = (state_reg != IDLE);

  always_comb begin
    state_next   = state_reg;
    o_cpu_enable = 1'b0;
    o_tx_valid   = 1'b0;
    o_tx_data    = 8'h00;
    o_imem_we    = 1'b0;
    o_reg_addr   = 5'd0;
    case (state_reg)
      IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == CMD_LOAD)      state_next = LD_CNT0;
          else if (i_rx_data == CMD_RUN)  state_next = RUN;
          else if (i_rx_data == CMD_STEP) state_next = STEP;
        end
      end
      LD_CNT0: if (i_rx_valid) state_next = LD_CNT1;
      LD_CNT1: begin
        if (i_rx_valid)
          state_next = ({i_rx_data, word_cnt_reg[7:0]} == 16'd0) ? ACK : LD_DATA;
      end
      LD_DATA: if (i_rx_valid && byte_idx_reg == 2'd3) state_next = LD_WR;
      LD_WR: begin
        o_imem_we  = 1'b1;
        state_next = (word_cnt_reg == 16'd1) ? ACK : LD_DATA;
      end
      // Halt gates enable combinationally so the core never advances past it.
      RUN: begin
        o_cpu_enable = ~i_halt;
        if (i_halt) state_next = DUMP_RD;
      end
      STEP: begin
        o_cpu_enable = ~i_halt;
        state_next   = DUMP_RD;
      end
      DUMP_RD: begin
        if (dump_cnt_reg[7:2] == 6'd0) begin
          state_next = DUMP_TX;
        end else begin
          // Word k of the dump is GPR k-1; word 32 wraps to address 31.
          o_reg_addr = dump_cnt_reg[6:2] - 5'd1;
          if (rd_phase_reg) state_next = DUMP_TX;
        end
      end
      DUMP_TX: begin
        o_tx_valid = 1'b1;
        o_tx_data  = tx_word_reg[7:0];
        if (i_tx_ready) begin
          if (dump_cnt_reg == DUMP_LAST)     state_next = IDLE;
          else if (dump_cnt_reg[1:0] == 2'd3) state_next = DUMP_RD;
        end
      end
      ACK: begin
        o_tx_valid = 1'b1;
        o_tx_data  = ACK_BYTE;
        if (i_tx_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      word_cnt_reg  <= 16'd0;
      addr_reg      <= '0;
      byte_idx_reg  <= 2'd0;
      data_sr_reg   <= 32'd0;
      dump_cnt_reg  <= 8'd0;
      rd_phase_reg  <= 1'b0;
      tx_word_reg   <= 32'd0;
      cpu_reset_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (i_rx_valid) begin
            if (i_rx_data == CMD_LOAD) begin
              cpu_reset_reg <= 1'b1;
              addr_reg      <= '0;
            end else if (i_rx_data == CMD_RUN || i_rx_data == CMD_STEP) begin
              cpu_reset_reg <= 1'b0;
            end
          end
        end
        LD_CNT0: if (i_rx_valid) word_cnt_reg[7:0] <= i_rx_data;
        LD_CNT1: begin
          if (i_rx_valid) begin
            word_cnt_reg[15:8] <= i_rx_data;
            byte_idx_reg       <= 2'd0;
          end
        end
        // Shifting in from the top leaves the first (LSB) byte at [7:0] after four bytes.
        LD_DATA: begin
          if (i_rx_valid) begin
            data_sr_reg  <= {i_rx_data, data_sr_reg[31:8]};
            byte_idx_reg <= byte_idx_reg + 2'd1;
          end
        end
        LD_WR: begin
          addr_reg     <= addr_reg + ADDR_ONE;
          word_cnt_reg <= word_cnt_reg - 16'd1;
          if (i_rx_valid && word_cnt_reg != 16'd1) begin
            data_sr_reg  <= {i_rx_data, data_sr_reg[31:8]};
            byte_idx_reg <= 2'd1;
          end
        end
        RUN, STEP: begin
          dump_cnt_reg <= 8'd0;
          rd_phase_reg <= 1'b0;
        end
        DUMP_RD: begin
          if (dump_cnt_reg[7:2] == 6'd0) begin
            tx_word_reg <= i_pc;
          end else if (!rd_phase_reg) begin
            rd_phase_reg <= 1'b1;
          end else begin
            rd_phase_reg <= 1'b0;
            tx_word_reg  <= i_reg_data;
          end
        end
        DUMP_TX: begin
          if (i_tx_ready) begin
            tx_word_reg  <= {8'h00, tx_word_reg[31:8]};
            dump_cnt_reg <= dump_cnt_reg + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_debug_unit.sv
// Scoreboard bench for mips_debug_unit: tiny core/regfile model, queued expectations for tx bytes
// and imem writes, and a negedge monitor that pops and compares them.
module tb_mips_debug_unit;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    i_rx_data = 8'h00;
  logic          i_rx_valid = 1'b0;
  logic [7:0]    o_tx_data;
  logic          o_tx_valid;
  logic          i_tx_ready = 1'b1;
  logic          o_imem_we;
  logic [AW-1:0] o_imem_addr;
  logic [31:0]   o_imem_wdata;
  logic          o_cpu_reset;
  logic          o_cpu_enable;
  logic          i_halt;
  logic [31:0]   i_pc;
  logic [4:0]    o_reg_addr;
  logic [31:0]   i_reg_data;
  logic          o_busy;

  int checks = 0;
  int errors = 0;
  logic [7:0]    exp_tx[$];
  logic [AW-1:0] exp_we_addr[$];
  logic [31:0]   exp_we_data[$];
  logic [31:0]   load_words[$];
  logic [31:0]   rf [32];
  logic [31:0]   core_pc = 32'd0;
  logic [31:0]   reg_q = 32'd0;
  int unsigned   en_pos = 0;
  int unsigned   en_base = 0;
  int unsigned   halt_limit = 32'hFFFF_FFFF;
  int unsigned   steps = 0;
  int            ready_mode = 0;
  int            tx_seen = 0;
  int            we_seen = 0;

  always #5 clk = ~clk;

  mips_debug_unit #(.IMEM_ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_wdata(o_imem_wdata),
    .o_cpu_reset(o_cpu_reset), .o_cpu_enable(o_cpu_enable), .i_halt(i_halt),
    .i_pc(i_pc), .o_reg_addr(o_reg_addr), .i_reg_data(i_reg_data), .o_busy(o_busy)
  );

  // Core stand-in: PC advances by 4 per enabled cycle; register file reads with one cycle latency.
  always @(posedge clk) begin
    if (o_cpu_reset) core_pc <= 32'd0;
    else if (o_cpu_enable) core_pc <= core_pc + 32'd4;
    if (o_cpu_enable) en_pos <= en_pos + 1;
    reg_q <= rf[o_reg_addr];
  end
  assign i_pc       = core_pc;
  assign i_reg_data = reg_q;
  assign i_halt     = (en_pos - en_base) >= halt_limit;

  initial begin
    int cyc;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (ready_mode == 0) i_tx_ready = 1'b1;
      else if (ready_mode == 1) i_tx_ready = (cyc % 3 == 0);
      else i_tx_ready = $urandom_range(0, 1) == 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a byte or an imem write.
  initial begin
    logic       pend;
    logic [7:0] pend_data;
    logic       prev_we;
    pend = 1'b0;
    prev_we = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pend = 1'b0;
        prev_we = 1'b0;
      end else begin
        if (pend) begin
          chk("tx_hold_valid", o_tx_valid, 1);
          if (o_tx_valid) chk("tx_hold_data", o_tx_data, pend_data);
        end
        pend = 1'b0;
        if (o_tx_valid) begin
          chk("tx_enable_low", o_cpu_enable, 0);
          if (i_tx_ready) begin
            if (exp_tx.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL tx_unexpected: got %02h, expected no byte", o_tx_data);
            end else begin
              chk("tx_byte", o_tx_data, exp_tx.pop_front());
            end
            tx_seen++;
          end else begin
            pend = 1'b1;
            pend_data = o_tx_data;
          end
        end
        if (o_imem_we) begin
          we_seen++;
          chk("we_single_cycle", prev_we, 0);
          chk("we_cpu_reset", o_cpu_reset, 1);
          if (exp_we_addr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL we_unexpected: got addr %0h, expected no write", o_imem_addr);
          end else begin
            chk("we_addr", o_imem_addr, exp_we_addr.pop_front());
            chk("we_data", o_imem_wdata, exp_we_data.pop_front());
          end
        end
        prev_we = o_imem_we;
      end
    end
  end

  task automatic randomize_rf();
    rf[0] = 32'd0;
    for (int r = 1; r < 32; r++) rf[r] = $urandom;
  endtask

  task automatic push_word(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int b = 0; b < 4; b++) begin
      exp_tx.push_back(t[7:0]);
      t = t >> 8;
    end
  endtask

  task automatic push_dump(input logic [31:0] pc);
    push_word(pc);
    for (int r = 0; r < 32; r++) push_word(rf[r]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(posedge clk);
    #1;
    i_rx_valid = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (o_busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle"}, o_busy, 0);
    chk({name, "_tx_drained"}, exp_tx.size(), 0);
    chk({name, "_we_drained"}, exp_we_addr.size(), 0);
    chk({name, "_idle_enable"}, o_cpu_enable, 0);
  endtask

  task automatic do_load();
    int n;
    int we0;
    int unsigned e0;
    logic [31:0] w;
    n = load_words.size();
    we0 = we_seen;
    e0 = en_pos;
    for (int i = 0; i < n; i++) begin
      exp_we_addr.push_back(AW'(i));
      exp_we_data.push_back(load_words[i]);
    end
    exp_tx.push_back(8'h06);
    steps = 0;
    send_byte(8'h4C);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    for (int i = 0; i < n; i++) begin
      w = load_words[i];
      for (int b = 0; b < 4; b++) begin
        send_byte(w[7:0]);
        w = w >> 8;
      end
    end
    wait_idle("load");
    chk("load_we_count", we_seen - we0, n);
    chk("load_no_enable", en_pos - e0, 0);
    chk("load_cpu_reset_held", o_cpu_reset, 1);
    $display("load: %0d words, ack seen at %0t", n, $time);
    load_words.delete();
  endtask

  task automatic do_step();
    int t0;
    t0 = tx_seen;
    randomize_rf();
    halt_limit = 32'hFFFF_FFFF;
    en_base = en_pos;
    steps += 1;
    push_dump(steps * 4);
    send_byte(8'h53);
    wait_idle("step");
    chk("step_enables", en_pos - en_base, 1);
    chk("step_dump_len", tx_seen - t0, 132);
    $display("step: pc model %0h, dump of %0d bytes at %0t", steps * 4, tx_seen - t0, $time);
  endtask

  task automatic do_run(input int unsigned lim);
    int t0;
    t0 = tx_seen;
    halt_limit = lim;
    en_base = en_pos;
    steps += lim;
    push_dump(steps * 4);
    send_byte(8'h52);
    wait_idle("run");
    chk("run_enables", en_pos - en_base, lim);
    chk("run_dump_len", tx_seen - t0, 132);
    $display("run: halt after %0d cycles, pc model %0h at %0t", lim, steps * 4, $time);
    halt_limit = 32'hFFFF_FFFF;
  endtask

  initial begin
    int base;
    int n;
    int k;
    logic [7:0] g;

    randomize_rf();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpu_reset", o_cpu_reset, 1);
    chk("rst_tx_valid", o_tx_valid, 0);
    chk("rst_tx_data", o_tx_data, 0);
    chk("rst_imem_we", o_imem_we, 0);
    chk("rst_imem_addr", o_imem_addr, 0);
    chk("rst_imem_wdata", o_imem_wdata, 0);
    chk("rst_cpu_enable", o_cpu_enable, 0);
    chk("rst_reg_addr", o_reg_addr, 0);
    chk("rst_busy", o_busy, 0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Two-word program, then an empty load.
    load_words.push_back(32'h20010005);
    load_words.push_back(32'h20020064);
    do_load();
    do_load();

    // Run with halt after 10 enabled cycles; $1/$2 land in dump bytes 8..15.
    rf[1] = 32'd5;
    rf[2] = 32'd100;
    do_run(10);

    // Two steps with a slow transmitter.
    ready_mode = 1;
    do_step();
    do_step();

    // Reset in the middle of a dump, then a fresh step.
    ready_mode = 2;
    randomize_rf();
    halt_limit = 32'hFFFF_FFFF;
    en_base = en_pos;
    push_dump((steps + 1) * 4);
    base = tx_seen;
    send_byte(8'h53);
    n = 0;
    while (tx_seen - base < 50 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk("abort_at_byte50", tx_seen - base, 50);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_tx_valid", o_tx_valid, 0);
    chk("abort_cpu_reset", o_cpu_reset, 1);
    chk("abort_busy", o_busy, 0);
    exp_tx.delete();
    steps = 0;
    $display("abort: reset after %0d dump bytes at %0t", tx_seen - base, $time);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    do_step();
    ready_mode = 0;

    // Unknown command byte, then a load that wraps the address.
    send_byte(8'h41);
    repeat (3) @(negedge clk);
    chk("ignore_unknown_busy", o_busy, 0);
    for (int i = 0; i < (1 << AW) + 1; i++) load_words.push_back($urandom);
    do_load();

    // Randomized command mix.
    for (int it = 0; it < 8; it++) begin
      ready_mode = $urandom_range(0, 2);
      k = $urandom_range(0, 3);
      if (k == 0) begin
        for (int i = 0; i < $urandom_range(0, 4); i++) load_words.push_back($urandom);
        do_load();
      end else if (k == 1) begin
        do_step();
      end else if (k == 2) begin
        randomize_rf();
        do_run($urandom_range(0, 15));
      end else begin
        g = 8'h4C;
        while (g == 8'h4C || g == 8'h52 || g == 8'h53) g = 8'($urandom_range(0, 255));
        send_byte(g);
        @(negedge clk);
        chk("random_ignore_busy", o_busy, 0);
        $display("ignored byte %02h at %0t", g, $time);
      end
    end

    repeat (4) @(negedge clk);
    chk("final_tx_drained", exp_tx.size(), 0);
    chk("final_we_drained", exp_we_addr.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
